reorder_buffer: RTL



---
 rtl/reorder_buffer_if.sv | 59 +++++
 rtl/reorder_buffer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// Bundle of decoder, writeback, register-file and fetch-redirect signals around the reorder buffer.
// The slave modport is the buffer itself; master is everything that talks to it.
interface reorder_buffer_if #(
  parameter int ROB_W = 3
);
  logic             rdy;
  logic             issue_valid;
  logic             issue_has_rd;
  logic [4:0]       issue_rd;
  logic             full;
  logic [ROB_W-1:0] alloc_rob_id;

  logic             wb_valid;
  logic [ROB_W-1:0] wb_rob_id;
  logic [31:0]      wb_value;
  logic             wb_mispredict;
  logic [31:0]      wb_target_pc;

  logic             need_set_reg_value;
  logic [4:0]       set_value_reg_id;
  logic [31:0]      set_val;
  logic [ROB_W-1:0] set_reg_rob_id;

  logic             need_set_reg_dep;
  logic [4:0]       set_dep_reg_id;
  logic [ROB_W-1:0] set_dep_rob_id;

  logic [ROB_W-1:0] need_rob_id1;
  logic [ROB_W-1:0] need_rob_id2;
  logic             rob_value1_ready;
  logic             rob_value2_ready;
  logic [31:0]      rob_value1;
  logic [31:0]      rob_value2;

  logic             clear;
  logic [31:0]      redirect_pc;

  modport slave (
    input  rdy, issue_valid, issue_has_rd, issue_rd,
    input  wb_valid, wb_rob_id, wb_value, wb_mispredict, wb_target_pc,
    input  need_rob_id1, need_rob_id2,
    output full, alloc_rob_id,
    output need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id,
    output need_set_reg_dep, set_dep_reg_id, set_dep_rob_id,
    output rob_value1_ready, rob_value2_ready, rob_value1, rob_value2,
    output clear, redirect_pc
  );

  modport master (
    output rdy, issue_valid, issue_has_rd, issue_rd,
    output wb_valid, wb_rob_id, wb_value, wb_mispredict, wb_target_pc,
    output need_rob_id1, need_rob_id2,
    input  full, alloc_rob_id,
    input  need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id,
    input  need_set_reg_dep, set_dep_reg_id, set_dep_rob_id,
    input  rob_value1_ready, rob_value2_ready, rob_value1, rob_value2,
    input  clear, redirect_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation and retirement, out-of-order result capture,
// operand lookup with writeback bypass, and a one-cycle flush after a mispredicted branch retires.
module reorder_buffer #(
  parameter int ROB_W = 3
) (
  input logic           clk,
  input logic           rst,
  reorder_buffer_if.slave bus
);
  localparam int              DEPTH      = 1 << ROB_W;
  localparam logic [ROB_W:0]  FULL_COUNT = (ROB_W+1)'(DEPTH);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] ready;
  logic [ROB_W-1:0] head;
  logic [ROB_W-1:0] tail;
  logic [ROB_W:0]   count;
  logic             clear_q;
  logic [31:0]      redirect_q;

  logic             has_rd_mem [DEPTH];
  logic [4:0]       rd_mem     [DEPTH];
  logic [31:0]      value_mem  [DEPTH];
  logic             mis_mem    [DEPTH];
  logic [31:0]      target_mem [DEPTH];

  logic active;
  logic full_c;
  logic do_alloc;
  logic do_wb;
  logic do_commit;
  logic hit1;
  logic hit2;

  // Folding rst into the enable keeps the same-cycle strobes quiet while reset is held.
  assign active    = rst && bus.rdy;
  assign full_c    = (count == FULL_COUNT) || clear_q;
  assign do_alloc  = active && bus.issue_valid && !full_c;
  assign do_wb     = active && !clear_q && bus.wb_valid && busy[bus.wb_rob_id];
  assign do_commit = active && !clear_q && busy[head] && ready[head];

  assign bus.full         = full_c;
  assign bus.alloc_rob_id = tail;

  assign bus.need_set_reg_dep = do_alloc && bus.issue_has_rd && (bus.issue_rd != 5'd0);
  assign bus.set_dep_reg_id   = bus.issue_rd;
  assign bus.set_dep_rob_id   = tail;

  assign bus.need_set_reg_value = do_commit && has_rd_mem[head] && (rd_mem[head] != 5'd0);
  assign bus.set_value_reg_id   = rd_mem[head];
  assign bus.set_val            = value_mem[head];
  assign bus.set_reg_rob_id     = head;

  assign bus.clear       = clear_q;
  assign bus.redirect_pc = redirect_q;

  // Lookups see a result broadcast in the same cycle it appears on the bus.
  assign hit1 = bus.wb_valid && (bus.wb_rob_id == bus.need_rob_id1);
  assign hit2 = bus.wb_valid && (bus.wb_rob_id == bus.need_rob_id2);

  assign bus.rob_value1_ready = busy[bus.need_rob_id1] && (ready[bus.need_rob_id1] || hit1);
  assign bus.rob_value2_ready = busy[bus.need_rob_id2] && (ready[bus.need_rob_id2] || hit2);
  assign bus.rob_value1 = !busy[bus.need_rob_id1] ? 32'd0 :
                          hit1 ? bus.wb_value : value_mem[bus.need_rob_id1];
  assign bus.rob_value2 = !busy[bus.need_rob_id2] ? 32'd0 :
                          hit2 ? bus.wb_value : value_mem[bus.need_rob_id2];

  // Head and tail never collide on one edge: a commit needs count>0, an allocation needs count<DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      ready      <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      clear_q    <= 1'b0;
      redirect_q <= '0;
    end else if (bus.rdy) begin
      if (clear_q) begin
        busy    <= '0;
        ready   <= '0;
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        clear_q <= 1'b0;
      end else begin
        if (do_alloc) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + ROB_W'(1);
        end
        if (do_wb) begin
          ready[bus.wb_rob_id] <= 1'b1;
        end
        if (do_commit) begin
          busy[head] <= 1'b0;
          head       <= head + ROB_W'(1);
        end
        count   <= count + (ROB_W+1)'(do_alloc) - (ROB_W+1)'(do_commit);
        clear_q <= do_commit && mis_mem[head];
        if (do_commit && mis_mem[head]) begin
          redirect_q <= target_mem[head];
        end
      end
    end
  end

  // NOTE: payload storage has no reset; busy/ready gate every use, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      has_rd_mem[tail] <= bus.issue_has_rd;
      rd_mem[tail]     <= bus.issue_rd;
      mis_mem[tail]    <= 1'b0;
    end
    if (do_wb) begin
      value_mem[bus.wb_rob_id]  <= bus.wb_value;
      mis_mem[bus.wb_rob_id]    <= bus.wb_mispredict;
      target_mem[bus.wb_rob_id] <= bus.wb_target_pc;
    end
  end
endmodule
